// File: rtl/pe_regfile_sb_if.sv
// Bus bundle between a CGRA processing element and its scoreboarded register file.
// The master drives channel data, write/read/send controls; the slave returns operands and status.
interface pe_regfile_sb_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int NIN   = 4,
  parameter int NOUT  = 4
);
  logic [NIN*DW-1:0]  chan_in;
  logic [NIN-1:0]     in_sel;
  logic [AW-1:0]      in_addr;
  logic               wb_en;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic [NIN-1:0]     rd1_bypass;
  logic [NIN-1:0]     rd2_bypass;
  logic [AW-1:0]      rd1_addr;
  logic [AW-1:0]      rd2_addr;
  logic               rd1_consume;
  logic               rd2_consume;
  logic [DW-1:0]      rd1_data;
  logic [DW-1:0]      rd2_data;
  logic               rd1_valid;
  logic               rd2_valid;
  logic [AW-1:0]      send_addr;
  logic [NOUT-1:0]    send_mask;
  logic [NOUT*DW-1:0] chan_out;
  logic [NOUT-1:0]    send_valid;
  logic               clr;
  logic [AW:0]        occ;
  logic               err_sel;
  logic               err_coll;

  modport master (
    output chan_in, in_sel, in_addr, wb_en, wb_addr, wb_data,
           rd1_bypass, rd2_bypass, rd1_addr, rd2_addr, rd1_consume, rd2_consume,
           send_addr, send_mask, clr,
    input  rd1_data, rd2_data, rd1_valid, rd2_valid, chan_out, send_valid,
           occ, err_sel, err_coll
  );

  modport slave (
    input  chan_in, in_sel, in_addr, wb_en, wb_addr, wb_data,
           rd1_bypass, rd2_bypass, rd1_addr, rd2_addr, rd1_consume, rd2_consume,
           send_addr, send_mask, clr,
    output rd1_data, rd2_data, rd1_valid, rd2_valid, chan_out, send_valid,
           occ, err_sel, err_coll
  );
endinterface

// File: rtl/pe_regfile_sb.sv
// PE register file with per-entry valid scoreboard, consume-on-read, write-back forwarding,
// input bypass, registered multi-channel send, occupancy counter and sticky error flags.
module pe_regfile_sb #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int NIN   = 4,
  parameter int NOUT  = 4
) (
  input  logic             i_clk_sys,
  input  logic             i_rst_b,
  pe_regfile_sb_if.slave   io_rf
);

  logic [DW-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [AW:0]        r_occ;
  logic [NOUT*DW-1:0] r_chan_out;
  logic [NOUT-1:0]    r_send_valid;
  logic               r_err_sel;
  logic               r_err_coll;

  function automatic logic f_onehot(input logic [NIN-1:0] v);
    return (v != '0) && ((v & (v - NIN'(1))) == '0);
  endfunction

  // AND-OR mux; only meaningful for a one-hot select
  function automatic logic [DW-1:0] f_chan(input logic [NIN-1:0] sel,
                                           input logic [NIN*DW-1:0] chans);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NIN; k++)
      if (sel[k]) d = d | chans[k*DW +: DW];
    return d;
  endfunction

  // Returns {valid, data}: bypass, then write-back forward, then the array
  function automatic logic [DW:0] f_read(input logic [NIN-1:0]    byp,
                                         input logic [NIN*DW-1:0] chans,
                                         input logic              fwd,
                                         input logic [DW-1:0]     fwd_data,
                                         input logic              vld,
                                         input logic [DW-1:0]     mem_word);
    if (byp != '0)
      return f_onehot(byp) ? {1'b1, f_chan(byp, chans)} : '0;
    if (fwd) return {1'b1, fwd_data};
    if (vld) return {1'b1, mem_word};
    return '0;
  endfunction

  logic          w_in_oh;
  logic          w_in_bad;
  logic          w_coll;
  logic          w_in_we;
  logic [DW-1:0] w_in_data;
  logic          w_sel_bad;
  logic          w_fwd1, w_fwd2;
  logic          w_cons1, w_cons2;
  logic          w_wr1, w_wr2;
  logic          w_dec1, w_dec2;
  logic          w_inc_in, w_inc_wb;
  logic [AW:0]   w_occ_nxt;

  assign w_in_oh   = f_onehot(io_rf.in_sel);
  assign w_in_bad  = (io_rf.in_sel != '0) && !w_in_oh;
  assign w_coll    = w_in_oh && io_rf.wb_en && (io_rf.in_addr == io_rf.wb_addr);
  assign w_in_we   = w_in_oh && !w_coll;
  assign w_in_data = f_chan(io_rf.in_sel, io_rf.chan_in);
  assign w_sel_bad = w_in_bad
                   || ((io_rf.rd1_bypass != '0) && !f_onehot(io_rf.rd1_bypass))
                   || ((io_rf.rd2_bypass != '0) && !f_onehot(io_rf.rd2_bypass));

  assign w_fwd1 = io_rf.wb_en && (io_rf.wb_addr == io_rf.rd1_addr);
  assign w_fwd2 = io_rf.wb_en && (io_rf.wb_addr == io_rf.rd2_addr);

  assign {io_rf.rd1_valid, io_rf.rd1_data} = f_read(io_rf.rd1_bypass, io_rf.chan_in, w_fwd1,
                                                    io_rf.wb_data, r_valid[io_rf.rd1_addr],
                                                    r_mem[io_rf.rd1_addr]);
  assign {io_rf.rd2_valid, io_rf.rd2_data} = f_read(io_rf.rd2_bypass, io_rf.chan_in, w_fwd2,
                                                    io_rf.wb_data, r_valid[io_rf.rd2_addr],
                                                    r_mem[io_rf.rd2_addr]);

  assign w_cons1 = io_rf.rd1_consume && (io_rf.rd1_bypass == '0) && io_rf.rd1_valid;
  assign w_cons2 = io_rf.rd2_consume && (io_rf.rd2_bypass == '0) && io_rf.rd2_valid;
  assign w_wr1   = (w_in_we && (io_rf.in_addr == io_rf.rd1_addr)) || w_fwd1;
  assign w_wr2   = (w_in_we && (io_rf.in_addr == io_rf.rd2_addr)) || w_fwd2;

  // Occupancy moves only on real valid transitions; a same-address double consume counts once
  assign w_dec1   = !io_rf.clr && w_cons1 && r_valid[io_rf.rd1_addr] && !w_wr1;
  assign w_dec2   = !io_rf.clr && w_cons2 && r_valid[io_rf.rd2_addr] && !w_wr2
                  && !(w_dec1 && (io_rf.rd1_addr == io_rf.rd2_addr));
  assign w_inc_in = w_in_we && (io_rf.clr || !r_valid[io_rf.in_addr]);
  assign w_inc_wb = io_rf.wb_en && (io_rf.clr || !r_valid[io_rf.wb_addr]);

  always_comb begin
    w_occ_nxt = io_rf.clr ? '0 : r_occ;
    w_occ_nxt = w_occ_nxt + (AW+1)'(w_inc_in) + (AW+1)'(w_inc_wb)
              - (AW+1)'(w_dec1) - (AW+1)'(w_dec2);
  end

  always_ff @(posedge i_clk_sys) begin
    if (w_in_we)     r_mem[io_rf.in_addr] <= w_in_data;
    if (io_rf.wb_en) r_mem[io_rf.wb_addr] <= io_rf.wb_data;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_valid      <= '0;
      r_occ        <= '0;
      r_chan_out   <= '0;
      r_send_valid <= '0;
      r_err_sel    <= 1'b0;
      r_err_coll   <= 1'b0;
    end else begin
      if (io_rf.clr) begin
        r_valid <= '0;
      end else begin
        if (w_cons1) r_valid[io_rf.rd1_addr] <= 1'b0;
        if (w_cons2) r_valid[io_rf.rd2_addr] <= 1'b0;
      end
      // Writes are applied last so they override consume and clr
      if (w_in_we)     r_valid[io_rf.in_addr] <= 1'b1;
      if (io_rf.wb_en) r_valid[io_rf.wb_addr] <= 1'b1;
      r_occ      <= w_occ_nxt;
      r_err_sel  <= w_sel_bad || (r_err_sel && !io_rf.clr);
      r_err_coll <= w_coll || (r_err_coll && !io_rf.clr);
      for (int k = 0; k < NOUT; k++) begin
        r_send_valid[k]         <= io_rf.send_mask[k] && r_valid[io_rf.send_addr];
        r_chan_out[k*DW +: DW]  <= (io_rf.send_mask[k] && r_valid[io_rf.send_addr])
                                   ? r_mem[io_rf.send_addr] : '0;
      end
    end
  end

  assign io_rf.chan_out   = r_chan_out;
  assign io_rf.send_valid = r_send_valid;
  assign io_rf.occ        = r_occ;
  assign io_rf.err_sel    = r_err_sel;
  assign io_rf.err_coll   = r_err_coll;

endmodule
